axis_frame_arbiter: RTL and testbench

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_frame_arbiter.sv | 120 ++++++++++++
 tb/tb_axis_frame_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-locked round-robin arbiter merging AXI-Stream sources onto one registered output
module axis_frame_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 8,
    localparam int IW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [IW-1:0]                 m_axis_tid,
    input  logic                          m_axis_tready,
    output logic                          busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [IW-1:0]         tid_q, tid_d;

    logic [IW-1:0]         pick;
    logic                  found;
    int                    idx;
    logic                  src_ready;
    logic                  xfer;

    // Rotating search starting just after the previous winner
    always_comb begin
        pick  = grant_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_SRC;
            if (!found && s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        s_axis_tready = '0;
        src_ready     = !tvalid_q || m_axis_tready;
        xfer          = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                s_axis_tready[grant_q] = src_ready;
                xfer = s_axis_tvalid[grant_q] && src_ready;
                if (xfer && s_axis_tlast[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register is a one-deep skid-free pipeline stage, decoupled from the FSM
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        if (xfer) begin
            tdata_d  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            tlast_d  = s_axis_tlast[grant_q];
            tid_d    = grant_q;
            tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_SRC - 1);
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tid_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tid_q        <= tid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign busy          = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - scoreboard and vector-table bench for axis_frame_arbiter
module tb_axis_frame_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           arstn;
    logic [N*W-1:0] s_axis_tdata;
    logic [N-1:0]   s_axis_tvalid;
    logic [N-1:0]   s_axis_tlast;
    logic [N-1:0]   s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic [IW-1:0]  m_axis_tid;
    logic           m_axis_tready;
    logic           busy;

    always #5 clk = ~clk;

    axis_frame_arbiter #(.NUM_SRC(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tready(m_axis_tready), .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic          last;
        logic [IW-1:0] tid;
    } beat_t;

    typedef struct {
        logic [N-1:0] mask;
        int           n;
        int           seq [3];
    } vec_t;

    beat_t      sb [$];
    int         out_cyc [$];
    logic [W:0] src_mem [N][32];
    int         src_wr [N];
    int         src_rd [N];
    logic       src_en [N];
    logic       mready_v;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       s_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_frame(input int src, input logic [7:0] base, input int len);
        for (int b = 0; b < len; b++) begin
            src_mem[src][src_wr[src]] = {logic'(b == len - 1), 8'(base + b)};
            src_wr[src]++;
        end
    endtask

    task automatic expect_frame(input int src, input logic [7:0] base, input int len);
        for (int b = 0; b < len; b++)
            sb.push_back('{8'(base + b), logic'(b == len - 1), 2'(src)});
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && src_rd[i] < src_wr[i]) begin
                s_axis_tvalid[i]        = 1'b1;
                s_axis_tdata[i*W +: W]  = src_mem[i][src_rd[i]][W-1:0];
                s_axis_tlast[i]         = src_mem[i][src_rd[i]][W];
            end else begin
                s_axis_tvalid[i]        = 1'b0;
                s_axis_tdata[i*W +: W]  = '0;
                s_axis_tlast[i]         = 1'b0;
            end
        end
        m_axis_tready = mready_v;
    endtask

    task automatic monitor();
        beat_t got, e;
        s_busy = busy;
        for (int i = 0; i < N; i++)
            if (s_axis_tvalid[i] && s_axis_tready[i]) src_rd[i]++;
        if (m_axis_tvalid && m_axis_tready) begin
            got = '{m_axis_tdata, m_axis_tlast, m_axis_tid};
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", got);
            end else begin
                e = sb.pop_front();
                chk("beat{data,last,tid}", 32'(got), 32'(e));
            end
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        arstn    = 1'b0;
        mready_v = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            src_en[i] = 1'b1;
        end
        sb.delete();
        out_cyc.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
    endtask

    vec_t tbl [8];
    int   k;
    int   busy_cnt;

    initial begin
        // Round-robin vectors: each masked source offers one single-beat frame at once
        tbl[0] = '{3'b111, 3, '{0, 1, 2}};
        tbl[1] = '{3'b110, 2, '{1, 2, 0}};
        tbl[2] = '{3'b101, 2, '{0, 2, 0}};
        tbl[3] = '{3'b011, 2, '{0, 1, 0}};
        tbl[4] = '{3'b101, 2, '{2, 0, 0}};
        tbl[5] = '{3'b100, 1, '{2, 0, 0}};
        tbl[6] = '{3'b010, 1, '{1, 0, 0}};
        tbl[7] = '{3'b011, 2, '{0, 1, 0}};

        arstn    = 1'b0;
        mready_v = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            src_en[i] = 1'b1;
        end
        drive();
        @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_m_tdata",  32'(m_axis_tdata), 0);
        chk("rst_m_tlast",  32'(m_axis_tlast), 0);
        chk("rst_m_tid",    32'(m_axis_tid), 0);
        chk("rst_s_tready", 32'(s_axis_tready), 0);
        chk("rst_busy",     32'(busy), 0);

        // Single source, 3-beat frame, latency and back-to-back output
        do_reset();
        k = cyc;
        load_frame(0, 8'h11, 3);
        sb.push_back('{8'h11, 1'b0, 2'd0});
        sb.push_back('{8'h22, 1'b0, 2'd0});
        sb.push_back('{8'h33, 1'b1, 2'd0});
        src_mem[0][1] = {1'b0, 8'h22};
        src_mem[0][2] = {1'b1, 8'h33};
        drain(20);
        if (out_cyc.size() == 3) begin
            chk("single_first_latency", 32'(out_cyc[0] - k), 2);
            chk("single_gap01", 32'(out_cyc[1] - out_cyc[0]), 1);
            chk("single_gap12", 32'(out_cyc[2] - out_cyc[1]), 1);
        end

        // Fairness between two continuously valid sources
        do_reset();
        for (int f = 0; f < 2; f++) begin
            load_frame(0, 8'(8'h20 + 4 * f), 2);
            load_frame(1, 8'(8'h30 + 4 * f), 2);
            expect_frame(0, 8'(8'h20 + 4 * f), 2);
            expect_frame(1, 8'(8'h30 + 4 * f), 2);
        end
        drain(40);
        if (out_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++)
                chk($sformatf("fair_gap%0d", i), 32'(out_cyc[i] - out_cyc[i-1]), (i % 2 == 1) ? 1 : 2);
        end

        // Backpressure mid-frame for 4 cycles
        do_reset();
        k = cyc;
        load_frame(0, 8'h50, 4);
        expect_frame(0, 8'h50, 4);
        for (int n = 0; n < 16; n++) begin
            logic stall;
            mready_v = !(cyc >= k + 3 && cyc < k + 7);
            stall    = !mready_v;
            cycle();
            if (stall) begin
                chk("bp_tvalid", 32'(m_axis_tvalid), 1);
                chk("bp_tdata",  32'(m_axis_tdata), 32'h51);
                chk("bp_tid",    32'(m_axis_tid), 0);
                chk("bp_tready", 32'(s_axis_tready), 0);
            end
        end
        mready_v = 1'b1;
        drain(20);

        // No preemption: src1 arrives during src0's 5-beat frame
        do_reset();
        load_frame(0, 8'h60, 5);
        load_frame(1, 8'h70, 1);
        expect_frame(0, 8'h60, 5);
        expect_frame(1, 8'h70, 1);
        src_en[1] = 1'b0;
        cycle();
        cycle();
        src_en[1] = 1'b1;
        drain(40);

        // Asynchronous reset mid-frame, then src0 wins first again
        do_reset();
        load_frame(0, 8'h80, 4);
        expect_frame(0, 8'h80, 4);
        for (int n = 0; n < 30 && out_cyc.size() < 2; n++) cycle();
        chk("mid_frame_beats_before_reset", 32'(out_cyc.size()), 2);
        arstn = 1'b0;
        #1;
        chk("async_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("async_rst_busy",   32'(busy), 0);
        do_reset();
        load_frame(0, 8'h90, 1);
        load_frame(1, 8'h98, 1);
        expect_frame(0, 8'h90, 1);
        expect_frame(1, 8'h98, 1);
        drain(20);

        // Only src2 valid after src0 won: one-beat frame, busy for one cycle
        do_reset();
        load_frame(0, 8'hA0, 1);
        expect_frame(0, 8'hA0, 1);
        drain(20);
        cycle();
        k        = cyc;
        busy_cnt = 0;
        load_frame(2, 8'hC0, 1);
        expect_frame(2, 8'hC0, 1);
        for (int n = 0; n < 5; n++) begin
            cycle();
            busy_cnt += int'(s_busy);
        end
        chk("src2_busy_cycles", 32'(busy_cnt), 1);
        chk("src2_latency", 32'(out_cyc[out_cyc.size()-1] - k), 2);
        chk("src2_drained", 32'(sb.size()), 0);

        // Table-driven round-robin vectors
        do_reset();
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < N; s++)
                if (tbl[r].mask[s]) load_frame(s, 8'(8'h40 + 16 * r + s), 1);
            for (int j = 0; j < tbl[r].n; j++)
                expect_frame(tbl[r].seq[j], 8'(8'h40 + 16 * r + tbl[r].seq[j]), 1);
            drain(30);
            cycle();
            chk($sformatf("vec%0d_idle", r), 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
